// File: rtl/exception_unit_if.sv
// Exception unit bus: per-stage exception requests from the pipeline and the
// report/flush/status outputs returned to it.
interface exception_unit_if;
    logic        stall;
    logic [31:0] if_pc;
    logic        if_addr_err;
    logic [31:0] id_pc;
    logic        id_ri;
    logic        id_syscall;
    logic [31:0] ex_pc;
    logic        ex_ovf;
    logic        ex_tr;
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic        mem_addrl;
    logic        mem_addrs;
    logic        exl;
    logic [69:0] exception_bus;
    logic [3:0]  flush;
    logic        busy;
    logic        panic;
    logic [7:0]  exc_count;

    // Pipeline side: raises requests, consumes the report.
    modport master (
        output stall, if_pc, if_addr_err, id_pc, id_ri, id_syscall,
               ex_pc, ex_ovf, ex_tr, mem_pc, mem_addr, mem_addrl, mem_addrs, exl,
        input  exception_bus, flush, busy, panic, exc_count
    );

    // Exception unit side.
    modport slave (
        input  stall, if_pc, if_addr_err, id_pc, id_ri, id_syscall,
               ex_pc, ex_ovf, ex_tr, mem_pc, mem_addr, mem_addrl, mem_addrs, exl,
        output exception_bus, flush, busy, panic, exc_count
    );
endinterface

// File: rtl/exception_unit.sv
// Exception unit: picks the oldest pending exception, reports it for one
// cycle, then holds the pipeline flush for DRAIN_CYCLES more cycles.
// A request seen while already at exception level raises a sticky panic.
module exception_unit #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    exception_unit_if.slave  bus_if
);
    typedef enum logic [1:0] {IDLE, REPORT, DRAIN} state_e;

    localparam logic [3:0] DRAIN_END = 4'(DRAIN_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [69:0] exc_bus_q, exc_bus_d;
    logic [3:0]  flush_q, flush_d;
    logic        busy_q, busy_d;
    logic        panic_q, panic_d;
    logic [7:0]  exc_count_q, exc_count_d;

    logic        req_any;
    logic [5:0]  win_flags;   // {ADDRL, ADDRS, SYSCALL, RI, OVF, TR}
    logic [31:0] win_epc;
    logic [31:0] win_badar;
    logic [3:0]  win_flush;

    // Winner selection: oldest stage first, then the fixed in-stage order.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        req_any   = bus_if.mem_addrl | bus_if.mem_addrs | bus_if.ex_ovf | bus_if.ex_tr |
                    bus_if.id_ri | bus_if.id_syscall | bus_if.if_addr_err;
        win_flags = '0;
        win_epc   = '0;
        win_badar = '0;
        win_flush = '0;
        if (bus_if.mem_addrl) begin
            win_flags = 6'b100000; win_epc = bus_if.mem_pc; win_badar = bus_if.mem_addr; win_flush = 4'b1111;
        end else if (bus_if.mem_addrs) begin
            win_flags = 6'b010000; win_epc = bus_if.mem_pc; win_badar = bus_if.mem_addr; win_flush = 4'b1111;
        end else if (bus_if.ex_ovf) begin
            win_flags = 6'b000010; win_epc = bus_if.ex_pc; win_flush = 4'b0111;
        end else if (bus_if.ex_tr) begin
            win_flags = 6'b000001; win_epc = bus_if.ex_pc; win_flush = 4'b0111;
        end else if (bus_if.id_ri) begin
            win_flags = 6'b000100; win_epc = bus_if.id_pc; win_flush = 4'b0011;
        end else if (bus_if.id_syscall) begin
            win_flags = 6'b001000; win_epc = bus_if.id_pc; win_flush = 4'b0011;
        end else if (bus_if.if_addr_err) begin
            win_flags = 6'b100000; win_epc = bus_if.if_pc; win_badar = bus_if.if_pc; win_flush = 4'b0001;
        end
    end

    // Next-state and next-output logic for the IDLE/REPORT/DRAIN sequence.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        exc_bus_d   = '0;
        flush_d     = flush_q;
        panic_d     = panic_q;
        exc_count_d = exc_count_q;
        unique case (state_q)
            IDLE: begin
                flush_d = '0;
                if (!bus_if.stall && req_any) begin
                    if (bus_if.exl) begin
                        panic_d = 1'b1;
                    end else begin
                        state_d     = REPORT;
                        exc_bus_d   = {win_flags, win_epc, win_badar};
                        flush_d     = win_flush;
                        drain_cnt_d = '0;
                        if (exc_count_q != 8'hFF) exc_count_d = exc_count_q + 8'd1;
                    end
                end
            end
            REPORT: state_d = DRAIN;
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 4'd1;
                if (drain_cnt_d == DRAIN_END) begin
                    state_d = IDLE;
                    flush_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            exc_bus_q   <= '0;
            flush_q     <= '0;
            busy_q      <= 1'b0;
            panic_q     <= 1'b0;
            exc_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            exc_bus_q   <= exc_bus_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
            panic_q     <= panic_d;
            exc_count_q <= exc_count_d;
        end
    end

    assign bus_if.exception_bus = exc_bus_q;
    assign bus_if.flush         = flush_q;
    assign bus_if.busy          = busy_q;
    assign bus_if.panic         = panic_q;
    assign bus_if.exc_count     = exc_count_q;
endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios plus a random phase, all
// checked each cycle against a queue-based model of expected outputs.
module tb_exception_unit;
    localparam int D = 2;

    typedef struct {
        logic [69:0] bus;
        logic [3:0]  flush;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    exception_unit_if bus_if ();

    exception_unit #(.DRAIN_CYCLES(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t cur;
    exp_t q[$];
    logic panic_m = 1'b0;
    int   count_m = 0;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus_if.stall = 0; bus_if.exl = 0;
        bus_if.if_addr_err = 0; bus_if.id_ri = 0; bus_if.id_syscall = 0;
        bus_if.ex_ovf = 0; bus_if.ex_tr = 0; bus_if.mem_addrl = 0; bus_if.mem_addrs = 0;
    endtask

    // Expected report for the current inputs, from the age/cause priority table.
    function automatic logic predict(output logic [69:0] bus, output logic [3:0] fl);
        logic [6:0]  r;
        int          stage [7];
        int          flag  [7];
        logic [31:0] pc    [4];
        r = {bus_if.mem_addrl, bus_if.mem_addrs, bus_if.ex_ovf, bus_if.ex_tr,
             bus_if.id_ri, bus_if.id_syscall, bus_if.if_addr_err};
        stage = '{3, 3, 2, 2, 1, 1, 0};
        flag  = '{5, 4, 1, 0, 2, 3, 5};
        pc    = '{bus_if.if_pc, bus_if.id_pc, bus_if.ex_pc, bus_if.mem_pc};
        bus = '0;
        fl  = '0;
        for (int i = 0; i < 7; i++) begin
            if (r[6 - i]) begin
                bus[64 + flag[i]] = 1'b1;
                bus[63:32] = pc[stage[i]];
                if (flag[i] >= 4) bus[31:0] = (stage[i] == 3) ? bus_if.mem_addr : bus_if.if_pc;
                fl = 4'((1 << (stage[i] + 1)) - 1);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // One clock: update the model from the inputs, take the edge, compare.
    task automatic step(input string tag);
        logic [69:0] b;
        logic [3:0]  f;
        exp_t        e;
        if (!cur.busy && !bus_if.stall && predict(b, f)) begin
            if (bus_if.exl) panic_m = 1'b1;
            else begin
                e.bus = b; e.flush = f; e.busy = 1'b1;
                q.push_back(e);
                e.bus = '0;
                for (int i = 0; i < D; i++) q.push_back(e);
                if (count_m < 255) count_m++;
            end
        end
        @(posedge clk);
        #1;
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{bus: '0, flush: '0, busy: 1'b0};
        check({tag, ".bus"},   bus_if.exception_bus, cur.bus);
        check({tag, ".flush"}, 70'(bus_if.flush),    70'(cur.flush));
        check({tag, ".busy"},  70'(bus_if.busy),     70'(cur.busy));
        check({tag, ".panic"}, 70'(bus_if.panic),    70'(panic_m));
        check({tag, ".count"}, 70'(bus_if.exc_count), 70'(count_m));
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, ".bus"},   bus_if.exception_bus, '0);
        check({tag, ".flush"}, 70'(bus_if.flush), '0);
        check({tag, ".busy"},  70'(bus_if.busy), '0);
        check({tag, ".panic"}, 70'(bus_if.panic), '0);
        check({tag, ".count"}, 70'(bus_if.exc_count), '0);
        q.delete();
        cur = '{bus: '0, flush: '0, busy: 1'b0};
        panic_m = 1'b0;
        count_m = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        cur = '{bus: '0, flush: '0, busy: 1'b0};
        clear_reqs();
        bus_if.if_pc = 32'h0040_0000; bus_if.id_pc = 32'h0040_0004;
        bus_if.ex_pc = 32'h0040_000C; bus_if.mem_pc = 32'h0040_0008;
        bus_if.mem_addr = 32'h0;

        // Reset state, observed before any clock edge.
        #3;
        check("rst.bus",   bus_if.exception_bus, '0);
        check("rst.flush", 70'(bus_if.flush), '0);
        check("rst.busy",  70'(bus_if.busy), '0);
        check("rst.panic", 70'(bus_if.panic), '0);
        check("rst.count", 70'(bus_if.exc_count), '0);
        @(negedge clk);
        reset = 1'b1;
        step("idle");

        // EX overflow.
        bus_if.ex_ovf = 1; bus_if.ex_pc = 32'h0040_0010;
        step("ovf");
        check("ovf.direct", bus_if.exception_bus, {6'b000010, 32'h0040_0010, 32'h0});
        check("ovf.flush_direct", 70'(bus_if.flush), 70'(4'b0111));
        check("ovf.count_direct", 70'(bus_if.exc_count), 70'd1);
        clear_reqs();
        for (int i = 0; i < 4; i++) step("ovf_drain");

        // MEM load address error beats ID syscall.
        bus_if.mem_addrl = 1; bus_if.mem_pc = 32'h0040_0008; bus_if.mem_addr = 32'h1000_0003;
        bus_if.id_syscall = 1;
        step("addrl");
        check("addrl.direct", bus_if.exception_bus, {6'b100000, 32'h0040_0008, 32'h1000_0003});
        check("addrl.flush_direct", 70'(bus_if.flush), 70'(4'b1111));
        clear_reqs();
        for (int i = 0; i < 4; i++) step("addrl_drain");

        // Stalled RI: no report until the stall drops.
        bus_if.id_ri = 1; bus_if.stall = 1;
        for (int i = 0; i < 3; i++) step("ri_stall");
        bus_if.stall = 0;
        step("ri");
        check("ri.flag_direct", 70'(bus_if.exception_bus[66]), 70'd1);
        clear_reqs();
        for (int i = 0; i < 4; i++) step("ri_drain");

        // Trap at exception level: panic, no report.
        bus_if.ex_tr = 1; bus_if.exl = 1;
        step("panic");
        check("panic.direct", 70'(bus_if.panic), 70'd1);
        check("panic.busy_direct", 70'(bus_if.busy), 70'd0);
        clear_reqs();
        for (int i = 0; i < 3; i++) step("panic_hold");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            clear_reqs();
            bus_if.if_pc = $urandom; bus_if.id_pc = $urandom;
            bus_if.ex_pc = $urandom; bus_if.mem_pc = $urandom; bus_if.mem_addr = $urandom;
            bus_if.stall = ($urandom_range(3) == 0);
            bus_if.exl   = ($urandom_range(40) == 0);
            if ($urandom_range(2) == 0) begin
                bus_if.mem_addrl   = ($urandom_range(3) == 0);
                bus_if.mem_addrs   = ($urandom_range(3) == 0);
                bus_if.ex_ovf      = ($urandom_range(3) == 0);
                bus_if.ex_tr       = ($urandom_range(3) == 0);
                bus_if.id_ri       = ($urandom_range(3) == 0);
                bus_if.id_syscall  = ($urandom_range(3) == 0);
                bus_if.if_addr_err = ($urandom_range(3) == 0);
            end
            step("rand");
        end
        clear_reqs();
        for (int i = 0; i < 4; i++) step("rand_drain");

        // Reset during DRAIN, then a fresh report.
        bus_if.ex_ovf = 1; bus_if.ex_pc = 32'h0040_0010;
        step("pre_rst");
        clear_reqs();
        step("pre_rst_report");
        step("pre_rst_drain");
        async_reset("mid_rst");
        bus_if.ex_ovf = 1;
        step("post_rst");
        check("post_rst.direct", bus_if.exception_bus, {6'b000010, 32'h0040_0010, 32'h0});
        clear_reqs();
        for (int i = 0; i < 4; i++) step("post_rst_drain");

        // Continuous requests: one report per 1+D+1 cycles, count saturates.
        bus_if.mem_addrs = 1; bus_if.mem_addr = 32'h2000_0001;
        for (int i = 0; i < 256 * (D + 2) + 8; i++) step("b2b");
        check("b2b.sat_direct", 70'(bus_if.exc_count), 70'(8'hFF));
        clear_reqs();
        for (int i = 0; i < 4; i++) step("b2b_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2, number of flush-hold cycles after a report (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port stall  input  1  pipeline stall; blocks request sampling.
REQ-005 SHALL have port if_pc  input  32  PC of IF-stage instruction.
REQ-006 SHALL have port if_addr_err  input  1  fetch address error (reported as ADDRL).
REQ-007 SHALL have port id_pc  input  32, plus id_ri  input  1 and id_syscall  input  1.
REQ-008 SHALL have port ex_pc  input  32, plus ex_ovf  input  1 and ex_tr  input  1.
REQ-009 SHALL have port mem_pc  input  32, plus mem_addr  input  32, mem_addrl  input  1 and mem_addrs  input  1.
REQ-010 SHALL have port exl  input  1  coprocessor SR exception-level bit.
REQ-011 SHALL have port exception_bus  output  70  [69]ADDRL [68]ADDRS [67]SYSCALL [66]RI [65]OVF [64]TR, [63:32] EPC, [31:0] BadAR.
REQ-012 SHALL have port flush  output  4  {mem,ex,id,if} stage-kill mask.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port panic  output  1  sticky double-fault flag.
REQ-015 SHALL have port exc_count  output  8  saturating count of reported exceptions.

Function
REQ-016 SHALL implement states IDLE, REPORT, DRAIN; IDLE->REPORT on accepted capture, REPORT->DRAIN unconditionally, DRAIN->IDLE when drain counter reaches DRAIN_CYCLES.
REQ-017 SHALL sample requests only in IDLE with stall=0; sampled request on edge N drives exception_bus in cycle N+1 for exactly one cycle (REPORT).
REQ-018 SHALL select one exception by age priority MEM > EX > ID > IF; within stage ADDRL > ADDRS, OVF > TR, RI > SYSCALL.
REQ-019 SHALL set exactly one flag bit in [69:64] during REPORT; all 70 bits SHALL be 0 in every other cycle.
REQ-020 SHALL load EPC with the winning stage's PC (mem_pc, ex_pc, id_pc or if_pc).
REQ-021 SHALL load BadAR with mem_addr for MEM ADDRL/ADDRS, if_pc for IF fetch error, else 0.
REQ-022 SHALL assert flush for the winning stage and every younger stage (MEM win = 4'b1111, EX = 4'b0111, ID = 4'b0011, IF = 4'b0001), held throughout REPORT and DRAIN, 0 in IDLE.
REQ-023 SHALL ignore all requests while in REPORT or DRAIN; stall SHALL NOT delay REPORT or DRAIN progression.
REQ-024 SHALL, if a request is sampled while exl=1, not enter REPORT, set panic, leave exception_bus 0, stay in IDLE.
REQ-025 SHALL keep panic set until reset.
REQ-026 SHALL increment exc_count by 1 on each REPORT entry, saturating at 8'hFF.
REQ-027 SHALL count DRAIN cycles with a 4-bit counter cleared on REPORT entry; DRAIN SHALL last exactly DRAIN_CYCLES cycles, so busy stays high for 1+DRAIN_CYCLES cycles.
REQ-028 SHALL treat simultaneous requests in multiple stages as a single exception (the winner); losers SHALL be discarded, not queued.

Reset
REQ-029 SHALL, while reset=0 and regardless of clock, force state IDLE, exception_bus=0, flush=0, busy=0, panic=0, exc_count=0, drain counter=0.
REQ-030 SHALL abort any REPORT/DRAIN on reset assertion with no partial output; first sampling SHALL occur on the first rising edge after reset=1.

Verification
REQ-031 SHALL test: ex_ovf=1, ex_pc=32'h0040_0010, exl=0 -> next cycle bus[65]=1, bus[63:32]=32'h0040_0010, BadAR=0, flush=4'b0111, busy for 3 cycles, exc_count=1.
REQ-032 SHALL test: same cycle mem_addrl=1 (mem_pc=32'h0040_0008, mem_addr=32'h1000_0003) and id_syscall=1 -> only bus[69]=1, EPC=32'h0040_0008, BadAR=32'h1000_0003, flush=4'b1111.
REQ-033 SHALL test: id_ri=1 with stall=1 for 3 cycles then stall=0 -> bus stays 0 while stalled, REPORT one cycle after stall drops, bus[66]=1.
REQ-034 SHALL test: ex_tr=1 with exl=1 -> bus stays 0, busy=0, panic=1 and remains 1 until reset.
REQ-035 SHALL test: reset=0 asserted during DRAIN -> flush, busy, exc_count, panic go 0 immediately without a clock edge; fresh request after release reports normally.
REQ-036 SHALL test: 256 back-to-back exceptions -> exc_count saturates at 8'hFF; requests arriving during REPORT/DRAIN produce no additional reports.
